// File: rtl/hazard_ctrl_unit_if.sv
// hazard_ctrl_unit_if: core-side hazard inputs and pipeline-control outputs of the hazard sequencer.
interface hazard_ctrl_unit_if #(parameter int REG_AW = 5);
  logic [REG_AW-1:0] rs1_id;
  logic [REG_AW-1:0] rs2_id;
  logic              use_rs1_id;
  logic              use_rs2_id;
  logic [REG_AW-1:0] rd_ex;
  logic              memread_ex;
  logic              branch_taken_ex;
  logic              mem_busy;
  logic              pc_write;
  logic              if_id_write;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic              pipe_hold;
  logic [1:0]        hz_state;
  logic              mem_timeout_err;
  logic [31:0]       perf_stall_cnt;
  logic [31:0]       perf_flush_cnt;
  modport master (
    output rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, memread_ex, branch_taken_ex, mem_busy,
    input  pc_write, if_id_write, flush_if_id, flush_id_ex, pipe_hold, hz_state, mem_timeout_err,
           perf_stall_cnt, perf_flush_cnt
  );
  modport slave (
    input  rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, memread_ex, branch_taken_ex, mem_busy,
    output pc_write, if_id_write, flush_if_id, flush_id_ex, pipe_hold, hz_state, mem_timeout_err,
           perf_stall_cnt, perf_flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: 5-stage pipeline sequencer for load-use bubbles, branch squashes and memory waits.
// Define HAZ_PERF_CNT_EN to add the stall/flush performance counters (otherwise the ports read 0).
module hazard_ctrl_unit #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 16,
  parameter int REG_AW       = 5
) (
  input logic              clk,
  input logic              rst,
  hazard_ctrl_unit_if.slave bus
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, MEMWAIT = 2'd2, BAD = 2'd3} state_t;
  state_t        r_state, w_next;
  logic [1:0]    r_flush_cnt, w_flush_cnt;
  logic [WW-1:0] r_wait_cnt;
  logic          r_err, w_load_use, w_pc, w_ifid, w_fif, w_fie, w_hold;
  assign w_load_use = bus.memread_ex && (bus.rd_ex != '0) &&
                      ((bus.use_rs1_id && bus.rs1_id == bus.rd_ex) ||
                       (bus.use_rs2_id && bus.rs2_id == bus.rd_ex));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= RUN;
      r_flush_cnt <= 2'd0;
      r_wait_cnt  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_flush_cnt <= w_flush_cnt;
      r_wait_cnt  <= !bus.mem_busy ? '0 : (r_wait_cnt == WW'(MEM_TIMEOUT)) ? r_wait_cnt : r_wait_cnt + 1'b1;
      r_err       <= r_err | (r_wait_cnt == WW'(MEM_TIMEOUT));
    end
  end
  // MEMWAIT shares RUN rules: busy keeps holding, release acts on the current inputs.
  always_comb begin
    w_next      = RUN;
    w_flush_cnt = r_flush_cnt;
    w_pc        = 1'b1;
    w_ifid      = 1'b1;
    w_fif       = 1'b0;
    w_fie       = 1'b0;
    w_hold      = 1'b0;
    case (r_state)
      RUN, MEMWAIT: begin
        if (bus.mem_busy) begin
          w_hold = 1'b1;
          w_pc   = 1'b0;
          w_ifid = 1'b0;
          w_next = MEMWAIT;
        end else if (bus.branch_taken_ex) begin
          w_fif = 1'b1;
          w_fie = 1'b1;
          if (FLUSH_CYCLES != 0) begin
            w_flush_cnt = 2'(FLUSH_CYCLES);
            w_next      = FLUSH;
          end
        end else if (w_load_use) begin
          w_pc   = 1'b0;
          w_ifid = 1'b0;
          w_fie  = 1'b1;
        end
      end
      FLUSH: begin
        w_fif = 1'b1;
        w_fie = 1'b1;
        if (bus.mem_busy) begin
          w_hold = 1'b1;
          w_pc   = 1'b0;
          w_ifid = 1'b0;
          w_next = FLUSH;
        end else begin
          w_flush_cnt = r_flush_cnt - 2'd1;
          w_next      = (r_flush_cnt <= 2'd1) ? RUN : FLUSH;
        end
      end
      default: w_next = RUN;
    endcase
  end
  assign bus.pc_write        = rst & w_pc;
  assign bus.if_id_write     = rst & w_ifid;
  assign bus.flush_if_id     = rst & w_fif;
  assign bus.flush_id_ex     = rst & w_fie;
  assign bus.pipe_hold       = rst & w_hold;
  assign bus.hz_state        = r_state;
  assign bus.mem_timeout_err = r_err;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_stall_cnt, r_flush_cnt_perf;
  // A flush_id_ex without flush_if_id can only be a load-use bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt      <= 32'd0;
      r_flush_cnt_perf <= 32'd0;
    end else begin
      r_stall_cnt      <= r_stall_cnt + 32'(w_hold | (w_fie & ~w_fif));
      r_flush_cnt_perf <= r_flush_cnt_perf + 32'(w_fif);
    end
  end
  assign bus.perf_stall_cnt = r_stall_cnt;
  assign bus.perf_flush_cnt = r_flush_cnt_perf;
`else
  assign bus.perf_stall_cnt = 32'd0;
  assign bus.perf_flush_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: directed vectors for hazard_ctrl_unit with hand-computed control outputs.
module tb_hazard_ctrl_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  always #5 clk = ~clk;
  hazard_ctrl_unit_if #(.REG_AW(5)) ifc ();
  hazard_ctrl_unit #(.FLUSH_CYCLES(1), .MEM_TIMEOUT(16), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .bus(ifc)
  );
  // observed = {pc_write, if_id_write, flush_if_id, flush_id_ex, pipe_hold, hz_state[1:0], mem_timeout_err}
  logic [7:0] w_obs;
  assign w_obs = {ifc.pc_write, ifc.if_id_write, ifc.flush_if_id, ifc.flush_id_ex,
                  ifc.pipe_hold, ifc.hz_state, ifc.mem_timeout_err};
  // input = {rs1, rs2, use1, use2, rd_ex, memread, branch, busy}
  localparam logic [19:0] IDLE  = 20'h0;
  localparam logic [19:0] BSY   = 20'h1;
  localparam logic [19:0] BR    = 20'h2;
  localparam logic [19:0] BRBSY = 20'h3;
  localparam logic [19:0] LU    = {5'd5, 5'd1, 1'b1, 1'b0, 5'd5, 1'b1, 2'b00};
  localparam logic [19:0] NOLU  = {5'd5, 5'd1, 1'b1, 1'b0, 5'd6, 1'b0, 2'b00};
  localparam logic [19:0] LU0   = {5'd0, 5'd1, 1'b1, 1'b1, 5'd0, 1'b1, 2'b00};
  localparam logic [19:0] LU2   = {5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 2'b00};
  localparam logic [19:0] LU2N  = {5'd1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 2'b00};

  task automatic apply(input logic [19:0] x);
    {ifc.rs1_id, ifc.rs2_id, ifc.use_rs1_id, ifc.use_rs2_id, ifc.rd_ex,
     ifc.memread_ex, ifc.branch_taken_ex, ifc.mem_busy} = x;
  endtask

  task automatic test_reset;
    apply(IDLE);
    #1;
    n_vec++;
    if (w_obs !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_low got %b want %b", w_obs, 8'h00);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if (w_obs !== 8'b1100_0000) begin
      n_bad++;
      $display("FAIL reset_release got %b want %b", w_obs, 8'b1100_0000);
    end
  endtask

  task automatic test_load_use;
    logic [27:0] v [6];
    v = '{{IDLE, 8'b1100_0000}, {LU, 8'b0001_0000}, {NOLU, 8'b1100_0000},
          {LU0, 8'b1100_0000}, {LU2, 8'b0001_0000}, {LU2N, 8'b1100_0000}};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      apply(v[i][27:8]);
      #1;
      n_vec++;
      if (w_obs !== v[i][7:0]) begin
        n_bad++;
        $display("FAIL load_use[%0d] got %b want %b", i, w_obs, v[i][7:0]);
      end
    end
  endtask

  task automatic test_branch;
    logic [27:0] v [6];
    v = '{{BR, 8'b1111_0000}, {IDLE, 8'b1111_0010}, {IDLE, 8'b1100_0000},
          {BR, 8'b1111_0000}, {LU, 8'b1111_0010}, {IDLE, 8'b1100_0000}};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      apply(v[i][27:8]);
      #1;
      n_vec++;
      if (w_obs !== v[i][7:0]) begin
        n_bad++;
        $display("FAIL branch[%0d] got %b want %b", i, w_obs, v[i][7:0]);
      end
    end
  endtask

  task automatic test_perf;
    logic [31:0] es, ef;
`ifdef HAZ_PERF_CNT_EN
    es = 32'd2;
    ef = 32'd4;
`else
    es = 32'd0;
    ef = 32'd0;
`endif
    @(negedge clk);
    apply(IDLE);
    #1;
    n_vec++;
    if (ifc.perf_stall_cnt !== es) begin
      n_bad++;
      $display("FAIL perf_stall got %0d want %0d", ifc.perf_stall_cnt, es);
    end
    n_vec++;
    if (ifc.perf_flush_cnt !== ef) begin
      n_bad++;
      $display("FAIL perf_flush got %0d want %0d", ifc.perf_flush_cnt, ef);
    end
  endtask

  task automatic test_mem_branch;
    logic [27:0] v [6];
    v = '{{BRBSY, 8'b0000_1000}, {BRBSY, 8'b0000_1100}, {BRBSY, 8'b0000_1100},
          {BR, 8'b1111_0100}, {IDLE, 8'b1111_0010}, {IDLE, 8'b1100_0000}};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      apply(v[i][27:8]);
      #1;
      n_vec++;
      if (w_obs !== v[i][7:0]) begin
        n_bad++;
        $display("FAIL mem_branch[%0d] got %b want %b", i, w_obs, v[i][7:0]);
      end
    end
  endtask

  task automatic test_flush_busy;
    logic [27:0] v [5];
    v = '{{BR, 8'b1111_0000}, {BSY, 8'b0011_1010}, {BSY, 8'b0011_1010},
          {IDLE, 8'b1111_0010}, {IDLE, 8'b1100_0000}};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      apply(v[i][27:8]);
      #1;
      n_vec++;
      if (w_obs !== v[i][7:0]) begin
        n_bad++;
        $display("FAIL flush_busy[%0d] got %b want %b", i, w_obs, v[i][7:0]);
      end
    end
  endtask

  task automatic test_timeout;
    logic [7:0] e;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      apply(i < 16 ? BSY : IDLE);
      e = (i == 0) ? 8'b0000_1000 : (i < 16) ? 8'b0000_1100 : (i == 16) ? 8'b1100_0100 : 8'b1100_0001;
      #1;
      n_vec++;
      if (w_obs !== e) begin
        n_bad++;
        $display("FAIL timeout[%0d] got %b want %b", i, w_obs, e);
      end
    end
  endtask

  task automatic test_reset_mid_flush;
    logic [27:0] v [2];
    v = '{{BR, 8'b1111_0001}, {IDLE, 8'b1111_0011}};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      apply(v[i][27:8]);
      #1;
      n_vec++;
      if (w_obs !== v[i][7:0]) begin
        n_bad++;
        $display("FAIL rst_flush_pre[%0d] got %b want %b", i, w_obs, v[i][7:0]);
      end
    end
    #1;
    rst = 1'b0;
    #1;
    n_vec++;
    if (w_obs !== 8'h00) begin
      n_bad++;
      $display("FAIL rst_flush_low got %b want %b", w_obs, 8'h00);
    end
    n_vec++;
    if ({ifc.perf_stall_cnt, ifc.perf_flush_cnt} !== 64'd0) begin
      n_bad++;
      $display("FAIL rst_perf got %0d/%0d want 0/0", ifc.perf_stall_cnt, ifc.perf_flush_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if (w_obs !== 8'b1100_0000) begin
      n_bad++;
      $display("FAIL rst_flush_release got %b want %b", w_obs, 8'b1100_0000);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (w_obs !== 8'b1100_0000) begin
      n_bad++;
      $display("FAIL rst_flush_residual got %b want %b", w_obs, 8'b1100_0000);
    end
  endtask

  initial begin
    test_reset;
    test_load_use;
    test_branch;
    test_perf;
    test_mem_branch;
    test_flush_busy;
    test_timeout;
    test_reset_mid_flush;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
